rtc_bus_master: RTL and testbench
=================================

RTC_BUS_MASTER -- requirements
Module: rtc_bus_master

Interface
REQ-001 Parameter PHASE_CYC, default 4: clk cycles per bus phase, legal range 2..15.
REQ-002 Parameter GAP_CYC, default 2: idle cycles with all strobes high between phases, legal range 1..15.
REQ-003 clk  in  1  single system clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  1  host presents a transaction.
REQ-006 req_write  in  1  1 = write, 0 = read.
REQ-007 req_addr  in  8  RTC register address.
REQ-008 req_wdata  in  8  write data.
REQ-009 req_ready  out  1  block can accept a request this cycle.
REQ-010 rsp_valid  out  1  one-cycle pulse: transaction complete.
REQ-011 rsp_rdata  out  8  read data, valid while rsp_valid=1.
REQ-012 CS  out  1  chip select, active low.
REQ-013 RD  out  1  read strobe, active low.
REQ-014 WR  out  1  write strobe, active low.
REQ-015 AD  out  1  0 = address phase, 1 = data phase.
REQ-016 DatAdd  inout  8  multiplexed address/data bus.

Function
REQ-017 States: IDLE, ADDR, GAP1, DATA, GAP2, DONE.
REQ-018 A request is accepted when req_valid=1 and req_ready=1; req_ready=1 only in IDLE.
REQ-019 On accept: req_write, req_addr and req_wdata are latched and the state goes IDLE->ADDR; later request-input changes have no effect.
REQ-020 ADDR: CS=0, WR=0, RD=1, AD=0; DatAdd driven with the latched address for PHASE_CYC cycles.
REQ-021 GAP1 and GAP2: CS=1, RD=1, WR=1, AD=1; DatAdd Hi-Z for GAP_CYC cycles.
REQ-022 DATA write: CS=0, WR=0, RD=1, AD=1; DatAdd driven with the latched wdata for PHASE_CYC cycles.
REQ-023 DATA read: CS=0, WR=1, RD=0, AD=1; DatAdd Hi-Z; DatAdd sampled into rsp_rdata on the last DATA cycle.
REQ-024 DONE lasts one cycle: rsp_valid=1, bus idle; the state then returns to IDLE.
REQ-025 Latency from the accept edge to rsp_valid = 2*PHASE_CYC + 2*GAP_CYC + 1 cycles (13 at defaults).
REQ-026 DatAdd is Hi-Z in every cycle other than ADDR and DATA-write; the block never drives while RD=0.
REQ-027 The phase counter is 4 bits, loads on phase entry and counts down to 1; no wrap.
REQ-028 rsp_rdata holds its last value until the next read completes; writes leave it unchanged.
REQ-029 req_valid=1 during DONE is not accepted; it is accepted in the following IDLE cycle, so back-to-back requests are separated by at least one IDLE cycle.

Reset
REQ-030 Reset values: state=IDLE, CS=RD=WR=AD=1, DatAdd Hi-Z, req_ready=1, rsp_valid=0, rsp_rdata=0x00.
REQ-031 Reset asserted mid-transaction aborts it on the next edge: no rsp_valid and no partial strobe after that edge.

Structure
REQ-032 A shared package holds the state enumeration, the bus-phase encoding of CS/RD/WR/AD, and the defaults for PHASE_CYC and GAP_CYC.
REQ-033 Sub-module phase_timer is a loadable down-counter with a terminal-count flag, used for both phase and gap timing.
REQ-034 All outputs, including the DatAdd output-enable, are registered.

Verification
REQ-035 The bench models the RTC: 16x8 memory with cell i = i; address decode 0x21..0x26 -> 1..6 and 0x31..0x33 -> 7..9; any other address -> 0.
REQ-036 Read 0x23 -> rsp_rdata=0x03, rsp_valid exactly 13 cycles after accept.
REQ-037 Write 0x24 with 0xA5, then read 0x24 -> rsp_rdata=0xA5; DatAdd is never driven by both sides.
REQ-038 Read unmapped address 0x7F -> rsp_rdata=0x00.
REQ-039 req_valid held high across two transactions -> two accepts with one IDLE cycle between them; strobe waveforms follow REQ-020..REQ-023.
REQ-040 Reset asserted in the 2nd DATA cycle of a read -> next cycle CS=RD=WR=AD=1, DatAdd Hi-Z, no rsp_valid, req_ready=1.

Source files
------------

// File: rtl/rtc_bus_master_pkg.sv
// Shared types for the RTC bus master: FSM states, strobe encodings and timing defaults.
package rtc_bus_master_pkg;

  localparam int unsigned PhaseCycDefault = 4;
  localparam int unsigned GapCycDefault   = 2;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StGap1,
    StData,
    StGap2,
    StDone
  } state_e;

  // Active-low strobes plus AD (0 = address phase).
  typedef struct packed {
    logic cs;
    logic rd;
    logic wr;
    logic ad;
  } bus_t;

  localparam bus_t BusIdle  = '{cs: 1'b1, rd: 1'b1, wr: 1'b1, ad: 1'b1};
  localparam bus_t BusAddr  = '{cs: 1'b0, rd: 1'b1, wr: 1'b0, ad: 1'b0};
  localparam bus_t BusWrite = '{cs: 1'b0, rd: 1'b1, wr: 1'b0, ad: 1'b1};
  localparam bus_t BusRead  = '{cs: 1'b0, rd: 1'b0, wr: 1'b1, ad: 1'b1};

  function automatic bus_t bus_enc(input state_e st, input logic write);
    bus_t b;
    b = BusIdle;
    case (st)
      StAddr:  b = BusAddr;
      StData:  b = write ? BusWrite : BusRead;
      default: b = BusIdle;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/rtc_bus_master_phase_timer.sv
// Loadable 4-bit down-counter; counts to 1 and holds, tc flags the last cycle of a phase.
module rtc_bus_master_phase_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       tc
);

  logic [3:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q > 4'd1) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  assign tc = (cnt_q == 4'd1);

endmodule

// File: rtl/rtc_bus_master.sv
// Host-to-RTC bus master: runs one address phase and one data phase on a muxed 8-bit bus.
module rtc_bus_master
  import rtc_bus_master_pkg::*;
#(
  parameter int unsigned PHASE_CYC = PhaseCycDefault,
  parameter int unsigned GAP_CYC   = GapCycDefault
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic       req_write,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       req_ready,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       CS,
  output logic       RD,
  output logic       WR,
  output logic       AD,
  inout  wire  [7:0] DatAdd
);

  state_e     state_q, state_d;
  logic       write_q, write_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  bus_t       bus_q;
  logic       oe_q;
  logic [7:0] dout_q;
  logic       ready_q;
  logic       rsp_valid_q;
  logic [7:0] rdata_q;
  logic       accept;
  logic       load;
  logic [3:0] load_val;
  logic       tc;

  rtc_bus_master_phase_timer u_phase_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .tc       (tc)
  );

  assign accept = (state_q == StIdle) && req_valid;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req_valid) state_d = StAddr;
      StAddr:  if (tc) state_d = StGap1;
      StGap1:  if (tc) state_d = StData;
      StData:  if (tc) state_d = StGap2;
      StGap2:  if (tc) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    write_d  = accept ? req_write : write_q;
    addr_d   = accept ? req_addr : addr_q;
    wdata_d  = accept ? req_wdata : wdata_q;
    load     = (state_d != state_q);
    load_val = ((state_d == StAddr) || (state_d == StData)) ? 4'(PHASE_CYC) : 4'(GAP_CYC);
  end

  // Outputs are computed from next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      bus_q       <= BusIdle;
      oe_q        <= 1'b0;
      dout_q      <= '0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      bus_q       <= bus_enc(state_d, write_d);
      oe_q        <= (state_d == StAddr) || ((state_d == StData) && write_d);
      dout_q      <= (state_d == StAddr) ? addr_d : wdata_d;
      ready_q     <= (state_d == StIdle);
      rsp_valid_q <= (state_d == StDone);
      if ((state_q == StData) && !write_q && tc) begin
        rdata_q <= DatAdd;
      end
    end
  end

  assign DatAdd    = oe_q ? dout_q : 8'bz;
  assign CS        = bus_q.cs;
  assign RD        = bus_q.rd;
  assign WR        = bus_q.wr;
  assign AD        = bus_q.ad;
  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_rtc_bus_master.sv
// Directed bench for rtc_bus_master with a small RTC model on the shared bus (default timing).
module tb_rtc_bus_master;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_write = 1'b0;
  logic [7:0] req_addr = 8'h00;
  logic [7:0] req_wdata = 8'h00;
  logic       req_ready, rsp_valid;
  logic [7:0] rsp_rdata;
  logic       CS, RD, WR, AD;
  wire  [7:0] DatAdd;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  rtc_bus_master dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .CS        (CS),
    .RD        (RD),
    .WR        (WR),
    .AD        (AD),
    .DatAdd    (DatAdd)
  );

  // RTC model: 16 cells, cell i = i, fixed address decode.
  logic [7:0] rtc_mem [16];
  logic [7:0] rtc_addr = 8'h00;
  logic       rtc_oe;
  logic [7:0] rtc_rd;

  function automatic logic [3:0] rtc_decode(input logic [7:0] a);
    if (a >= 8'h21 && a <= 8'h26) return 4'(a - 8'h20);
    if (a >= 8'h31 && a <= 8'h33) return 4'(a - 8'h31 + 8'd7);
    return 4'd0;
  endfunction

  assign rtc_oe = !CS && !RD;
  assign rtc_rd = rtc_mem[rtc_decode(rtc_addr)];
  assign DatAdd = rtc_oe ? rtc_rd : 8'bz;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) rtc_mem[i] <= 8'(i);
    end else if (!CS && !WR) begin
      if (!AD) rtc_addr <= DatAdd;
      else if (rtc_decode(rtc_addr) != 4'd0) rtc_mem[rtc_decode(rtc_addr)] <= DatAdd;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // {CS,RD,WR,AD} expected in cycle c after the accept edge (PHASE_CYC=4, GAP_CYC=2).
  function automatic logic [3:0] exp_wave(input int c, input logic wr);
    if (c >= 1 && c <= 4) return 4'b0100;
    if (c >= 7 && c <= 10) return wr ? 4'b0101 : 4'b0011;
    return 4'b1111;
  endfunction

  task automatic run_txn(input string tag, input logic wr, input logic [7:0] a,
                         input logic [7:0] d, input logic [7:0] exp_rd);
    int lat = 0;
    int nrsp = 0;
    int bad = 0;
    logic [7:0] rd_seen = 8'h00;
    logic [7:0] bus_addr = 8'h00;
    logic [7:0] bus_data = 8'h00;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    check_eq({tag, " ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    // Scramble request inputs: the latched copy must be used.
    req_valid = 1'b0;
    req_write = ~wr;
    req_addr  = 8'hFF;
    req_wdata = ~d;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if ({CS, RD, WR, AD} !== exp_wave(c, wr)) bad++;
      if (c == 2) bus_addr = DatAdd;
      if (c == 8) bus_data = DatAdd;
      if (rsp_valid) begin
        nrsp++;
        if (lat == 0) begin
          lat = c;
          rd_seen = rsp_rdata;
        end
      end
    end
    check_eq({tag, " strobes"}, 32'(bad), 32'd0);
    check_eq({tag, " addr on bus"}, 32'(bus_addr), 32'(a));
    if (wr) check_eq({tag, " wdata on bus"}, 32'(bus_data), 32'(d));
    check_eq({tag, " latency"}, 32'(lat), 32'd13);
    check_eq({tag, " rsp count"}, 32'(nrsp), 32'd1);
    check_eq({tag, " rdata"}, 32'(rd_seen), 32'(exp_rd));
  endtask

  initial begin
    int a1 = -1;
    int a2 = -1;
    int nrsp = 0;
    int nlow = 0;
    logic [7:0] rd2 = 8'h00;
    logic       rdy_done = 1'b1;
    logic [3:0] w_addr = 4'h0, w_wr = 4'h0, w_rd = 4'h0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset strobes", 32'({CS, RD, WR, AD}), 32'hF);
    check_eq("reset ready", 32'(req_ready), 32'd1);
    check_eq("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("reset rdata", 32'(rsp_rdata), 32'h00);
    reset = 1'b0;

    run_txn("rd23", 1'b0, 8'h23, 8'h00, 8'h03);
    run_txn("wr24", 1'b1, 8'h24, 8'hA5, 8'h03);
    run_txn("rd24", 1'b0, 8'h24, 8'h00, 8'hA5);
    run_txn("rd7f", 1'b0, 8'h7F, 8'h00, 8'h00);
    run_txn("rd33", 1'b0, 8'h33, 8'h00, 8'h09);

    // req_valid held high: write 0x31, then a read of 0x31 accepted after one IDLE cycle.
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 8'h31;
    req_wdata = 8'h5C;
    for (int c = 0; c < 40; c++) begin
      if (req_valid && req_ready) begin
        if (a1 < 0) a1 = c;
        else if (a2 < 0) a2 = c;
      end
      if (rsp_valid) begin
        nrsp++;
        rd2 = rsp_rdata;
      end
      if (a1 >= 0 && c == a1 + 13) rdy_done = req_ready;
      if (a1 >= 0 && c == a1 + 1) w_addr = {CS, RD, WR, AD};
      if (a1 >= 0 && c == a1 + 7) w_wr = {CS, RD, WR, AD};
      if (a2 >= 0 && c == a2 + 7) w_rd = {CS, RD, WR, AD};
      if (a1 >= 0 && c == a1 + 1) req_write = 1'b0;
      if (a2 >= 0 && c == a2 + 1) req_valid = 1'b0;
      @(negedge clk);
    end
    req_valid = 1'b0;
    check_eq("b2b accept gap", 32'(a2 - a1), 32'd14);
    check_eq("b2b ready in DONE", 32'(rdy_done), 32'd0);
    check_eq("b2b rsp count", 32'(nrsp), 32'd2);
    check_eq("b2b read data", 32'(rd2), 32'h5C);
    check_eq("b2b addr strobes", 32'(w_addr), 32'h4);
    check_eq("b2b write strobes", 32'(w_wr), 32'h5);
    check_eq("b2b read strobes", 32'(w_rd), 32'h3);

    // Reset in the 2nd DATA cycle of a read of 0x22.
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 8'h22;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) @(negedge clk);
    check_eq("abort pre strobes", 32'({CS, RD, WR, AD}), 32'h3);
    reset = 1'b1;
    @(negedge clk);
    check_eq("abort strobes", 32'({CS, RD, WR, AD}), 32'hF);
    check_eq("abort rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("abort ready", 32'(req_ready), 32'd1);
    check_eq("abort rdata", 32'(rsp_rdata), 32'h00);
    reset = 1'b0;
    nrsp = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rsp_valid) nrsp++;
      if (!CS || !RD || !WR || !AD) nlow++;
    end
    check_eq("abort no rsp", 32'(nrsp), 32'd0);
    check_eq("abort no strobe", 32'(nlow), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
